// File: rtl/pps_holdover_gen.sv
// pps_holdover_gen: regenerates a clean one_pps from an external 1PPS input.
// It qualifies each external edge against the nominal second and locks after
// LOCK_COUNT good periods. When the reference disappears it free-runs at the
// last measured period.
module pps_holdover_gen #(
   parameter int unsigned NOMINAL    = 62500000,
   parameter int unsigned TOL        = 625,
   parameter int unsigned LOCK_COUNT = 3,
   parameter int unsigned PULSE_W    = 6250000,
   parameter int unsigned CW         = 27
) (
   input  logic          clk_62m5,
   input  logic          rst_n,
   input  logic          one_pps_ext,
   output logic          one_pps_out,
   output logic          locked,
   output logic          holdover,
   output logic [CW-1:0] period_meas,
   output logic [7:0]    missed_cnt
);

   localparam logic [1:0] ST_ACQ    = 2'd0;
   localparam logic [1:0] ST_LOCKED = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   localparam logic [CW-1:0] LO_LIM  = CW'(NOMINAL - TOL);
   localparam logic [CW-1:0] HI_LIM  = CW'(NOMINAL + TOL);
   localparam logic [CW-1:0] TO_LIM  = CW'(NOMINAL + TOL + 1);
   localparam logic [CW-1:0] NOM_V   = CW'(NOMINAL);
   localparam logic [CW-1:0] ONE     = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam logic [3:0]    LOCK_N  = 4'(LOCK_COUNT);
   localparam int            PW_W    = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
   localparam logic [PW_W-1:0] PW_LOAD = PW_W'(PULSE_W - 1);

   logic            s1_q, s2_q, s3_q;
   logic [CW-1:0]   per_cnt_q, per_cnt_d;
   logic [1:0]      state_q, state_d;
   logic            have_ref_q, have_ref_d;
   logic [3:0]      good_cnt_q, good_cnt_d;
   logic [CW-1:0]   ho_cnt_q, ho_cnt_d;
   logic [CW-1:0]   period_q, period_d;
   logic [7:0]      missed_q, missed_d;
   logic            fire_q, fire_d;
   logic            out_q;
   logic [PW_W-1:0] pw_q;
   logic            locked_q, holdover_q;

   logic            ext_edge, good, timeout;
   logic [CW-1:0]   meas;
   logic [7:0]      missed_inc;
   logic [3:0]      good_inc;

   assign ext_edge   = s2_q & ~s3_q;
   assign meas       = per_cnt_q;
   assign good       = (meas >= LO_LIM) && (meas <= HI_LIM);
   assign timeout    = (per_cnt_q == TO_LIM) && !ext_edge;
   assign missed_inc = (missed_q == 8'hFF) ? missed_q : missed_q + 8'd1;
   assign good_inc   = good_cnt_q + 4'd1;

   // The edge cycle counts as elapsed cycle 0, so the register reads 1 on the
   // following cycle and holds the exact edge-to-edge distance at the next edge.
   always_comb begin
      per_cnt_d = per_cnt_q;
      if (ext_edge)
         per_cnt_d = ONE;
      else if (per_cnt_q != CNT_MAX)
         per_cnt_d = per_cnt_q + ONE;
   end

   // Acquisition / lock / holdover decisions and the fire request.
   always_comb begin
      state_d    = state_q;
      have_ref_d = have_ref_q;
      good_cnt_d = good_cnt_q;
      ho_cnt_d   = ho_cnt_q;
      period_d   = period_q;
      missed_d   = missed_q;
      fire_d     = 1'b0;
      case (state_q)
         ST_ACQ: begin
            if (ext_edge) begin
               if (!have_ref_q) begin
                  have_ref_d = 1'b1;
               end else if (good) begin
                  period_d   = meas;
                  good_cnt_d = good_inc;
                  if (good_inc == LOCK_N) begin
                     state_d  = ST_LOCKED;
                     fire_d   = 1'b1;
                     missed_d = 8'd0;
                  end
               end else begin
                  good_cnt_d = 4'd0;
               end
            end else if (timeout) begin
               have_ref_d = 1'b0;
               good_cnt_d = 4'd0;
            end
         end
         ST_LOCKED: begin
            if (ext_edge) begin
               if (good) begin
                  fire_d   = 1'b1;
                  period_d = meas;
               end else begin
                  state_d    = ST_ACQ;
                  good_cnt_d = 4'd0;
               end
            end else if (timeout) begin
               state_d  = ST_HOLD;
               fire_d   = 1'b1;
               ho_cnt_d = '0;
               missed_d = missed_inc;
            end
         end
         ST_HOLD: begin
            if (ext_edge) begin
               state_d    = ST_ACQ;
               good_cnt_d = 4'd0;
               have_ref_d = 1'b1;
            end else if (ho_cnt_q == period_q - ONE) begin
               fire_d   = 1'b1;
               ho_cnt_d = '0;
               missed_d = missed_inc;
            end else begin
               ho_cnt_d = ho_cnt_q + ONE;
            end
         end
         default: state_d = ST_ACQ;
      endcase
   end

   // Input synchronizer, period counter and FSM state registers.
   always_ff @(posedge clk_62m5 or negedge rst_n) begin
      if (!rst_n) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
         per_cnt_q  <= '0;
         state_q    <= ST_ACQ;
         have_ref_q <= 1'b0;
         good_cnt_q <= 4'd0;
         ho_cnt_q   <= '0;
         period_q   <= NOM_V;
         missed_q   <= 8'd0;
         fire_q     <= 1'b0;
      end else begin
         s1_q       <= one_pps_ext;
         s2_q       <= s1_q;
         s3_q       <= s2_q;
         per_cnt_q  <= per_cnt_d;
         state_q    <= state_d;
         have_ref_q <= have_ref_d;
         good_cnt_q <= good_cnt_d;
         ho_cnt_q   <= ho_cnt_d;
         period_q   <= period_d;
         missed_q   <= missed_d;
         fire_q     <= fire_d;
      end
   end

   // Output pulse: a fire (re)loads the width counter; state changes never cut it short.
   always_ff @(posedge clk_62m5 or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= 1'b0;
         pw_q  <= '0;
      end else if (fire_q) begin
         out_q <= 1'b1;
         pw_q  <= PW_LOAD;
      end else if (out_q) begin
         if (pw_q == '0)
            out_q <= 1'b0;
         else
            pw_q <= pw_q - 1'b1;
      end
   end

   // Registered state decodes for status reporting.
   always_ff @(posedge clk_62m5 or negedge rst_n) begin
      if (!rst_n) begin
         locked_q   <= 1'b0;
         holdover_q <= 1'b0;
      end else begin
         locked_q   <= (state_q == ST_LOCKED);
         holdover_q <= (state_q == ST_HOLD);
      end
   end

   assign one_pps_out = out_q;
   assign locked      = locked_q;
   assign holdover    = holdover_q;
   assign period_meas = period_q;
   assign missed_cnt  = missed_q;

endmodule
